// File: rtl/snes_poll_sched_if.sv
// Reader handshake between the poll scheduler and the serial pad reader.
// The scheduler starts a read and picks the pad; the reader returns the buttons.
interface snes_poll_sched_if;
  logic       rd_start;
  logic       rd_sel;
  logic       rd_done;
  logic [7:0] rd_buttons;

  modport master (output rd_start, output rd_sel, input rd_done, input rd_buttons);
  modport slave  (input rd_start, input rd_sel, output rd_done, output rd_buttons);
endinterface

// File: rtl/snes_poll_sched.sv
// Poll scheduler for two SNES pads: triggers a read round from a period timer
// or vsync, reads pad 0 then pad 1 through one reader, latches buttons, flags timeouts.
//
// state | meaning
// IDLE  | waiting for a trigger with en=1
// START | restart the reader for pad rd_sel, clear timeout counter
// WAIT  | waiting for rd_done or timeout
// STORE | latch rd_buttons into pad[rd_sel]
// NEXT  | advance to pad 1, or finish the round
module snes_poll_sched #(
  parameter int SYSMHZ  = 100,
  parameter int POLL_US = 16667,
  parameter int TMO_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    vsync,
  input  logic                    use_vsync,
  snes_poll_sched_if.master       rd,
  output logic [7:0]              pad0,
  output logic [7:0]              pad1,
  output logic [1:0]              chg,
  output logic                    upd,
  output logic [1:0]              err
);

  localparam int unsigned PERIOD = SYSMHZ * POLL_US;
  localparam int          TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);
  localparam int          CW     = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_STORE, S_NEXT} state_t;

  state_t        state, nxt;
  logic          vs_s1, vs_s2, vs_s3;
  logic          vs_rise, tick, trig;
  logic [TW-1:0] tmr;
  logic [CW-1:0] tmo_cnt;
  logic          sel, sel_nxt;
  logic          rd_start_q;
  logic [7:0]    pad_q [2];
  logic          tmo_clr, tmo_inc, set_err, do_store, pulse_start, pulse_upd;

  // vs_s3 is the previous synchronised level, used only for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign vs_rise = vs_s2 & ~vs_s3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      tmr <= RELOAD;
    else if (!en || tmr == '0)
      tmr <= RELOAD;
    else
      tmr <= tmr - 1'b1;
  end

  assign tick = en & (tmr == '0);
  assign trig = use_vsync ? vs_rise : tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt         = state;
    sel_nxt     = sel;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
    set_err     = 1'b0;
    do_store    = 1'b0;
    pulse_start = 1'b0;
    pulse_upd   = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig && en) begin
          sel_nxt = 1'b0;
          nxt     = S_START;
        end
      end
      S_START: begin
        pulse_start = 1'b1;
        tmo_clr     = 1'b1;
        nxt         = S_WAIT;
      end
      S_WAIT: begin
        // rd_done takes priority over a coincident timeout
        if (rd.rd_done) begin
          nxt = S_STORE;
        end else if (tmo_cnt == TMO_LAST) begin
          set_err = 1'b1;
          nxt     = S_NEXT;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_STORE: begin
        do_store = 1'b1;
        nxt      = S_NEXT;
      end
      S_NEXT: begin
        if (!sel) begin
          sel_nxt = 1'b1;
          nxt     = S_START;
        end else begin
          pulse_upd = 1'b1;
          sel_nxt   = 1'b0;
          nxt       = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_start_q <= 1'b0;
      sel        <= 1'b0;
      pad_q[0]   <= 8'h00;
      pad_q[1]   <= 8'h00;
      chg        <= 2'b00;
      upd        <= 1'b0;
      err        <= 2'b00;
      tmo_cnt    <= '0;
    end else begin
      rd_start_q <= pulse_start;
      upd        <= pulse_upd;
      sel        <= sel_nxt;
      chg        <= 2'b00;
      if (tmo_clr)
        tmo_cnt <= '0;
      else if (tmo_inc)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (set_err)
        err[sel] <= 1'b1;
      if (do_store) begin
        pad_q[sel] <= rd.rd_buttons;
        err[sel]   <= 1'b0;
        chg[sel]   <= (pad_q[sel] != rd.rd_buttons);
      end
    end
  end

  assign rd.rd_start = rd_start_q;
  assign rd.rd_sel   = sel;
  assign pad0        = pad_q[0];
  assign pad1        = pad_q[1];

endmodule

// File: tb/tb_snes_poll_sched.sv
// Self-checking bench for snes_poll_sched: randomized read rounds against a
// transaction-level model of pad contents, change pulses and timeout flags.
module tb_snes_poll_sched;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, vsync, use_vsync;
  logic [7:0] pad0, pad1;
  logic [1:0] chg, err;
  logic       upd;

  snes_poll_sched_if rd_if ();

  snes_poll_sched #(.SYSMHZ(1), .POLL_US(100), .TMO_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .en(en), .vsync(vsync), .use_vsync(use_vsync),
    .rd(rd_if), .pad0(pad0), .pad1(pad1), .chg(chg), .upd(upd), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int n_chg0 = 0, n_chg1 = 0, n_upd = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (chg[0]) n_chg0++;
      if (chg[1]) n_chg1++;
      if (upd)    n_upd++;
    end
  end

  logic [7:0] m_pad [2];
  logic [1:0] m_err;
  logic [7:0] vals [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_rd_start(input int budget, output int t);
    bit seen = 0;
    t = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rd_if.rd_start) begin
        seen = 1;
        t = cyc;
      end
    end
    check("rd_start_seen", seen, 1);
  endtask

  task automatic wait_upd(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (upd) seen = 1;
    end
    check("upd_seen", seen, 1);
  endtask

  task automatic wait_quiet(input int n, input string tag);
    int hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (rd_if.rd_start || upd) hits++;
    end
    check(tag, hits, 0);
  endtask

  // called at the negedge where rd_start for pad p was observed
  task automatic serve(input int p, input bit a, input int d, input logic [7:0] v);
    if (a) begin
      repeat (d) @(negedge clk);
      rd_if.rd_done    = 1'b1;
      rd_if.rd_buttons = v;
      @(negedge clk);
      rd_if.rd_done    = 1'b0;
    end else begin
      repeat (TMO) @(negedge clk);
      check("err_hold", err[p], m_err[p]);
      @(negedge clk);
      check("err_set", err[p], 1);
    end
  endtask

  task automatic do_round(input bit a0, input int d0, input logic [7:0] v0,
                          input bit a1, input int d1, input logic [7:0] v1,
                          input bit extra, input bit drop_en, output int t0);
    int c0 = n_chg0, c1 = n_chg1, u0 = n_upd, t1;
    logic [1:0] xchg = 2'b00;
    wait_rd_start(150, t0);
    vsync = 1'b0;
    check("sel_pad0", rd_if.rd_sel, 0);
    if (drop_en) en = 1'b0;
    serve(0, a0, d0, v0);
    wait_rd_start(60, t1);
    check("sel_pad1", rd_if.rd_sel, 1);
    if (extra) vsync = 1'b1;
    serve(1, a1, d1, v1);
    wait_upd(60);
    vsync = 1'b0;
    if (a0) begin xchg[0] = (v0 != m_pad[0]); m_pad[0] = v0; m_err[0] = 1'b0; end
    else m_err[0] = 1'b1;
    if (a1) begin xchg[1] = (v1 != m_pad[1]); m_pad[1] = v1; m_err[1] = 1'b0; end
    else m_err[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("pad0", pad0, m_pad[0]);
    check("pad1", pad1, m_pad[1]);
    check("err", err, m_err);
    check("chg0_pulses", n_chg0 - c0, xchg[0]);
    check("chg1_pulses", n_chg1 - c1, xchg[1]);
    check("upd_pulses", n_upd - u0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0, t0, tp;
    vals = '{8'h00, 8'h11, 8'h5A, 8'hA5, 8'h3C, 8'hFF};
    m_pad[0] = 8'h00;
    m_pad[1] = 8'h00;
    m_err    = 2'b00;
    rstn = 1'b0; en = 1'b0; use_vsync = 1'b0; vsync = 1'b0;
    rd_if.rd_done = 1'b0; rd_if.rd_buttons = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outputs", {rd_if.rd_start, rd_if.rd_sel, pad0, pad1, chg, upd, err}, 0);
    rstn = 1'b1;

    // timer mode: held while disabled, then a round every 100 cycles
    wait_quiet(150, "en0_timer_quiet");
    @(negedge clk);
    c0 = cyc;
    en = 1'b1;
    do_round(1, 20, 8'hA5, 1, 20, 8'h3C, 0, 0, t0);
    check("lat_timer", t0 - c0, 101);
    tp = t0;
    do_round(1, 20, 8'hA5, 1, 20, 8'h3C, 0, 0, t0);
    check("period", t0 - tp, 100);
    tp = t0;
    for (int r = 0; r < 6; r++) begin
      do_round(1, $urandom_range(1, 40), vals[$urandom_range(0, 5)],
               1, $urandom_range(1, 40), vals[$urandom_range(0, 5)], 0, 0, t0);
      check("period", t0 - tp, 100);
      tp = t0;
    end
    en = 1'b0;
    wait_quiet(250, "en0_after_rounds");

    // vsync mode: timer ticks must not start rounds
    use_vsync = 1'b1;
    en = 1'b1;
    wait_quiet(250, "vsync_no_timer");
    @(negedge clk);
    c0 = cyc;
    vsync = 1'b1;
    do_round(1, 5, 8'h11, 1, 7, 8'h22, 0, 0, t0);
    check("lat_vsync", t0 - c0, 4);

    // pad1 timeout, then cleared by a good read; rd_done/timeout tie
    wait_quiet(8, "quiet");
    vsync = 1'b1;
    do_round(1, 10, 8'h33, 0, 0, 8'h00, 0, 0, t0);
    wait_quiet(8, "quiet");
    vsync = 1'b1;
    do_round(1, 50, 8'h44, 1, 50, 8'h55, 0, 0, t0);

    // rd_done while idle is ignored
    @(negedge clk);
    rd_if.rd_buttons = 8'hEE;
    rd_if.rd_done = 1'b1;
    @(negedge clk);
    rd_if.rd_done = 1'b0;
    c0 = n_chg0 + n_chg1;
    repeat (4) @(negedge clk);
    #1;
    check("idle_done_pad0", pad0, m_pad[0]);
    check("idle_done_pad1", pad1, m_pad[1]);
    check("idle_done_chg", n_chg0 + n_chg1 - c0, 0);

    // trigger with en=0 ignored
    en = 1'b0;
    vsync = 1'b1;
    wait_quiet(20, "en0_vsync_quiet");
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;

    // en dropped mid-round: round finishes, nothing new starts
    vsync = 1'b1;
    do_round(1, 12, 8'h66, 1, 9, 8'h66, 0, 1, t0);
    vsync = 1'b1;
    wait_quiet(20, "en_dropped_quiet");
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;

    // randomized vsync rounds with timeouts and dropped mid-round triggers
    for (int r = 0; r < 12; r++) begin
      wait_quiet(8, "no_queued_trigger");
      vsync = 1'b1;
      do_round($urandom_range(0, 4) != 0, $urandom_range(1, TMO), vals[$urandom_range(0, 5)],
               $urandom_range(0, 4) != 0, $urandom_range(1, TMO), vals[$urandom_range(0, 5)],
               $urandom_range(0, 1), 0, t0);
    end
    wait_quiet(8, "no_queued_trigger");

    // reset mid-WAIT after a dropped trigger
    if (m_pad[0] == 8'h00 && m_pad[1] == 8'h00) begin
      vsync = 1'b1;
      do_round(1, 3, 8'h77, 1, 3, 8'h88, 0, 0, t0);
      wait_quiet(8, "quiet");
    end
    vsync = 1'b1;
    wait_rd_start(20, t0);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_outputs", {rd_if.rd_start, rd_if.rd_sel, pad0, pad1, chg, upd, err}, 0);
    m_pad[0] = 8'h00;
    m_pad[1] = 8'h00;
    m_err    = 2'b00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_quiet(30, "after_reset_quiet");
    @(negedge clk);
    c0 = cyc;
    vsync = 1'b1;
    do_round(1, 15, 8'h99, 1, 25, 8'hAA, 0, 0, t0);
    check("lat_after_reset", t0 - c0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
